// File: rtl/afe_solution_core.sv
// rtl/afe_solution_core.sv - AFE board controller: SPI config/status port and COMP time-over-threshold counter
// Optional overflow saturation built when AFE_TOT_OVF_EN is defined.
`timescale 1ns/1ps
module afe_solution_core (
   input  logic       CLK,
   input  logic       RST_B,
   input  logic       SCLK,
   input  logic       CS_B,
   input  logic       MOSI,
   output logic       MISO,
   input  logic       INJ_IN,
   input  logic       COMP,
   output logic       HIT,
   output logic [7:0] GPIO,
   output logic       LED
);

   typedef enum logic [1:0] {S_IDLE, S_ARMED, S_COUNT} state_t;

   // sync vector order {COMP, INJ_IN, MOSI, CS_B, SCLK}; CS_B idles high
   localparam logic [4:0] SYNC_RST = 5'b00010;

   logic       rst_meta, rst_n;
   logic [4:0] sync_meta, sync_q;
   logic       sclk_d, cs_d, inj_d, comp_d;
   logic       sclk_s, cs_s, mosi_s, inj_s, comp_s;
   logic       sclk_rise, sclk_fall, cs_rise, cs_fall, inj_rise, inj_fall;

   logic [7:0]  shift_in;
   logic [4:0]  bit_cnt;
   logic [7:0]  config_q;
   logic [15:0] out_sh;
   logic        rd_clear;

   state_t      state;
   logic [13:0] tot, tot_inc;
   logic        valid, ovf_bit, meas_end;
`ifdef AFE_TOT_OVF_EN
   logic        tot_sat;
`endif

   always_ff @(posedge CLK or negedge RST_B) begin
      if (!RST_B) begin
         rst_meta <= 1'b0;
         rst_n    <= 1'b0;
      end else begin
         rst_meta <= 1'b1;
         rst_n    <= rst_meta;
      end
   end

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         sync_meta <= SYNC_RST;
         sync_q    <= SYNC_RST;
         sclk_d    <= 1'b0;
         cs_d      <= 1'b1;
         inj_d     <= 1'b0;
         comp_d    <= 1'b0;
      end else begin
         sync_meta <= {COMP, INJ_IN, MOSI, CS_B, SCLK};
         sync_q    <= sync_meta;
         sclk_d    <= sync_q[0];
         cs_d      <= sync_q[1];
         inj_d     <= sync_q[3];
         comp_d    <= sync_q[4];
      end
   end

   assign sclk_s = sync_q[0];
   assign cs_s   = sync_q[1];
   assign mosi_s = sync_q[2];
   assign inj_s  = sync_q[3];
   assign comp_s = sync_q[4];

   assign sclk_rise = sclk_s & ~sclk_d;
   assign sclk_fall = ~sclk_s & sclk_d;
   assign cs_rise   = cs_s & ~cs_d;
   assign cs_fall   = ~cs_s & cs_d;
   assign inj_rise  = inj_s & ~inj_d;
   assign inj_fall  = ~inj_s & inj_d;

   // out_sh is zeroed whenever CS_B is high, so MISO idles low without gating
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         shift_in <= 8'h00;
         bit_cnt  <= 5'd0;
         config_q <= 8'h00;
         out_sh   <= 16'h0000;
      end else if (cs_fall) begin
         bit_cnt <= 5'd0;
         out_sh  <= {valid, ovf_bit, tot};
      end else if (cs_rise) begin
         if (bit_cnt == 5'd8)
            config_q <= shift_in;
         out_sh <= 16'h0000;
      end else if (!cs_s) begin
         if (sclk_rise) begin
            shift_in <= {shift_in[6:0], mosi_s};
            if (bit_cnt != 5'd31)
               bit_cnt <= bit_cnt + 5'd1;
         end
         if (sclk_fall)
            out_sh <= {out_sh[14:0], 1'b0};
      end
   end

   assign rd_clear = cs_rise && (bit_cnt >= 5'd16);
   assign meas_end = ((state == S_ARMED) && !comp_s && inj_fall) ||
                     ((state == S_COUNT) && !comp_s);

   always_comb begin
      tot_inc = tot + 14'd1;
`ifdef AFE_TOT_OVF_EN
      tot_sat = (tot == 14'h3FFF);
      if (tot_sat)
         tot_inc = tot;
`endif
   end

`ifndef AFE_TOT_OVF_EN
   assign ovf_bit = 1'b0;
`endif

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         tot   <= 14'd0;
         valid <= 1'b0;
`ifdef AFE_TOT_OVF_EN
         ovf_bit <= 1'b0;
`endif
      end else begin
         // a measurement ending in the same cycle keeps its result
         if (rd_clear && !meas_end) begin
            valid <= 1'b0;
            tot   <= 14'd0;
`ifdef AFE_TOT_OVF_EN
            ovf_bit <= 1'b0;
`endif
         end
         case (state)
            S_IDLE: begin
               if (inj_rise) begin
                  tot   <= 14'd0;
`ifdef AFE_TOT_OVF_EN
                  ovf_bit <= 1'b0;
`endif
                  state <= S_ARMED;
               end
            end
            S_ARMED: begin
               if (comp_s) begin
                  tot   <= tot_inc;
`ifdef AFE_TOT_OVF_EN
                  if (tot_sat)
                     ovf_bit <= 1'b1;
`endif
                  state <= S_COUNT;
               end else if (inj_fall) begin
                  valid <= 1'b1;
                  state <= S_IDLE;
               end
            end
            S_COUNT: begin
               if (comp_s) begin
                  tot <= tot_inc;
`ifdef AFE_TOT_OVF_EN
                  if (tot_sat)
                     ovf_bit <= 1'b1;
`endif
               end else begin
                  valid <= 1'b1;
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign MISO = out_sh[15];
   assign HIT  = comp_s;
   assign GPIO = config_q;
   assign LED  = valid;

endmodule

// File: tb/tb_afe_solution_core.sv
// tb/tb_afe_solution_core.sv - scoreboard bench for afe_solution_core (SPI write/read, TOT, reset)
`timescale 1ns/1ps
module tb_afe_solution_core;

   logic       CLK = 1'b0;
   logic       RST_B = 1'b0;
   logic       SCLK = 1'b0;
   logic       CS_B = 1'b1;
   logic       MOSI = 1'b0;
   logic       INJ_IN = 1'b0;
   logic       COMP = 1'b0;
   logic       MISO, HIT, LED;
   logic [7:0] GPIO;

   afe_solution_core dut (
      .CLK(CLK), .RST_B(RST_B), .SCLK(SCLK), .CS_B(CS_B), .MOSI(MOSI), .MISO(MISO),
      .INJ_IN(INJ_IN), .COMP(COMP), .HIT(HIT), .GPIO(GPIO), .LED(LED)
   );

   always #12.5 CLK = ~CLK;

   typedef struct {
      bit          is_read;
      int          sel;
      logic [15:0] exp;
      string       name;
   } exp_t;

   exp_t        sb_q[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          probe_cnt = 0;
   int          rd_bits = 0;
   logic [15:0] rd_word = 16'h0;

`ifdef AFE_TOT_OVF_EN
   localparam logic [15:0] EXP_OVF = 16'hFFFF;
`else
   localparam logic [15:0] EXP_OVF = 16'h8074;
`endif

   task automatic compare(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge CLK);
   endtask

   // sel: 0 GPIO, 1 LED, 2 HIT, 3 MISO; sampled 1 ns after the next rising edge
   task automatic probe(input int sel, input logic [15:0] exp, input string name);
      exp_t e;
      e.is_read = 1'b0; e.sel = sel; e.exp = exp; e.name = name;
      sb_q.push_back(e);
      probe_cnt++;
   endtask

   task automatic spi_xfer(input int n, input logic [15:0] data);
      CS_B = 1'b0;
      for (int i = 0; i < n; i++) begin
         MOSI = data[n-1-i];
         wait_clk(4);
         SCLK = 1'b1;
         wait_clk(4);
         SCLK = 1'b0;
      end
      MOSI = 1'b0;
      wait_clk(4);
      CS_B = 1'b1;
   endtask

   task automatic spi_read(input logic [15:0] exp, input string name);
      exp_t e;
      e.is_read = 1'b1; e.sel = 0; e.exp = exp; e.name = name;
      sb_q.push_back(e);
      spi_xfer(16, 16'h0000);
   endtask

   task automatic measure(input int comp_cycles);
      INJ_IN = 1'b1;
      wait_clk(8);
      COMP = 1'b1;
      wait_clk(comp_cycles);
      COMP = 1'b0;
      wait_clk(8);
      INJ_IN = 1'b0;
      wait_clk(8);
   endtask

   initial begin
      exp_t        e;
      logic [15:0] act;
      forever begin
         @(posedge CLK);
         #1;
         if (probe_cnt > 0) begin
            probe_cnt--;
            if (sb_q.size() == 0 || sb_q[0].is_read) begin
               n_cmp++;
               n_bad++;
               $display("FAIL probe_order: queue size %0d, required a pending probe", sb_q.size());
            end else begin
               e = sb_q.pop_front();
               case (e.sel)
                  0:       act = {8'h00, GPIO};
                  1:       act = {15'h0, LED};
                  2:       act = {15'h0, HIT};
                  default: act = {15'h0, MISO};
               endcase
               compare(e.name, act, e.exp);
            end
         end
      end
   end

   always @(negedge CS_B) rd_bits = 0;

   always @(posedge SCLK) begin
      if (!CS_B) begin
         rd_word = {rd_word[14:0], MISO};
         rd_bits++;
      end
   end

   always @(posedge CS_B) begin
      exp_t e;
      if (rd_bits == 16) begin
         if (sb_q.size() == 0 || !sb_q[0].is_read) begin
            n_cmp++;
            n_bad++;
            $display("FAIL read_order: got 0x%04h with no read expectation pending", rd_word);
         end else begin
            e = sb_q.pop_front();
            compare(e.name, rd_word, e.exp);
         end
      end
   end

   initial begin
      wait_clk(5);
      RST_B = 1'b1;
      wait_clk(6);
      probe(0, 16'h0000, "rst_gpio");
      probe(1, 16'h0000, "rst_led");
      probe(2, 16'h0000, "rst_hit");
      probe(3, 16'h0000, "rst_miso");
      wait_clk(6);
      spi_read(16'h0000, "rd_reset");
      wait_clk(6);

      spi_xfer(8, 16'h00A5);
      wait_clk(3);
      probe(0, 16'h00A5, "wr_gpio_a5");
      probe(1, 16'h0000, "wr_led_kept");
      wait_clk(6);
      spi_xfer(7, 16'h003C);
      wait_clk(6);
      probe(0, 16'h00A5, "wr7_ignored");
      wait_clk(2);
      spi_xfer(9, 16'h01FF);
      wait_clk(6);
      probe(0, 16'h00A5, "wr9_ignored");
      wait_clk(2);

      INJ_IN = 1'b1;
      wait_clk(8);
      COMP = 1'b1;
      probe(2, 16'h0000, "hit_lag1");
      wait_clk(1);
      probe(2, 16'h0001, "hit_lag2");
      wait_clk(19);
      COMP = 1'b0;
      wait_clk(8);
      INJ_IN = 1'b0;
      wait_clk(8);
      probe(1, 16'h0001, "tot_led_set");
      wait_clk(2);
      spi_read(16'h8014, "rd_tot20");
      wait_clk(6);
      probe(1, 16'h0000, "led_read_clr");
      wait_clk(2);
      spi_read(16'h0000, "rd_after_clr");
      wait_clk(6);

      measure(5);
      spi_xfer(8, 16'h003C);
      wait_clk(3);
      probe(0, 16'h003C, "wr_gpio_3c");
      probe(1, 16'h0001, "led_kept_by_wr");
      wait_clk(4);
      spi_read(16'h8005, "rd_tot5");
      wait_clk(6);

      INJ_IN = 1'b1;
      wait_clk(40);
      INJ_IN = 1'b0;
      wait_clk(8);
      spi_read(16'h8000, "rd_nohit");
      wait_clk(6);

      measure(16500);
      spi_read(EXP_OVF, "rd_overflow");
      wait_clk(6);

      measure(7);
      CS_B = 1'b0;
      for (int i = 0; i < 3; i++) begin
         wait_clk(4);
         SCLK = 1'b1;
         wait_clk(4);
         SCLK = 1'b0;
      end
      RST_B = 1'b0;
      wait_clk(3);
      probe(0, 16'h0000, "midrst_gpio");
      probe(1, 16'h0000, "midrst_led");
      probe(3, 16'h0000, "midrst_miso");
      wait_clk(4);
      CS_B = 1'b1;
      wait_clk(2);
      RST_B = 1'b1;
      wait_clk(6);
      spi_read(16'h0000, "rd_post_rst");
      wait_clk(6);
      probe(0, 16'h0000, "post_rst_gpio");
      wait_clk(2);

      for (int k = 0; k < 200 && sb_q.size() != 0; k++) @(negedge CLK);
      if (sb_q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
